// File: rtl/dtree_pkg.sv
`default_nettype none
// ============================================================================
// dtree_pkg : shared types and constants for the dtree result transmitter
// Rev 1.0
// ============================================================================
package dtree_pkg;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;
  localparam int         FRAME_BYTES = 3;
  localparam int         STAMP_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    B0   = 2'd1,
    B1   = 2'd2,
    B2   = 2'd3
  } tx_state_t;

  typedef struct packed {
    logic [STAMP_WIDTH-1:0] stamp;
    logic [1:0]             level;
    logic [1:0]             path;
  } result_rec_t;

  localparam int REC_WIDTH = $bits(result_rec_t);

  // Byte presented on the link while the transmitter sits in state st.
  function automatic logic [7:0] frame_byte(input result_rec_t rec, input tx_state_t st);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      B0:      b = {SYNC_NIBBLE, rec.level, rec.path};
      B1:      b = rec.stamp[15:8];
      B2:      b = rec.stamp[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ============================================================================
// result_fifo : synchronous FIFO, wrap-bit pointers, async active-low reset
// Rev 1.0
// ============================================================================
module result_fifo #(
  parameter  int WIDTH = 20,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign count     = r_wr_ptr - r_rd_ptr;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign rdata     = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dtree_result_tx.sv
`default_nettype none
// ============================================================================
// dtree_result_tx : timestamps dtree results, buffers them, sends 3-byte frames
// Rev 1.0
// ============================================================================
module dtree_result_tx
  import dtree_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DROP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_strobe,
  input  logic                  in_valid,
  input  logic [1:0]            level,
  input  logic [1:0]            path,
  input  logic                  clear,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  overflow,
  output logic [DROP_WIDTH-1:0] drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [STAMP_WIDTH-1:0] r_stamp;
  logic                   r_overflow;
  logic [DROP_WIDTH-1:0]  r_drop_count;
  tx_state_t              r_state;
  tx_state_t              w_state_nxt;
  result_rec_t            r_frame;
  result_rec_t            w_frame_nxt;
  result_rec_t            w_rec;
  result_rec_t            w_head;
  logic                   r_tx_valid;
  logic [7:0]             r_tx_data;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_pop;
  logic [AW:0]            w_fifo_count_unused;

  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

  // The record takes the stamp before this cycle's strobe increment lands.
  assign w_rec  = {r_stamp, level, path};
  assign w_push = in_valid & ~w_full;
  assign w_drop = in_valid & w_full;

  result_fifo #(
    .WIDTH (REC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .wdata (w_rec),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_fifo_count_unused)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stamp <= '0;
    end else if (sample_strobe) begin
      r_stamp <= r_stamp + STAMP_WIDTH'(1);
    end
  end

  // A drop in the same cycle as clear restarts the count at one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clear) begin
        r_drop_count <= DROP_WIDTH'(1);
      end else if (!(&r_drop_count)) begin
        r_drop_count <= r_drop_count + DROP_WIDTH'(1);
      end
    end else if (clear) begin
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = B0;
        end
      end
      B0: if (tx_ready) w_state_nxt = B1;
      B1: if (tx_ready) w_state_nxt = B2;
      B2: begin
        if (tx_ready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = B0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_frame_nxt = w_pop ? w_head : r_frame;

  // Outputs are precomputed from the next state so they leave a flop directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_frame    <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_frame    <= w_frame_nxt;
      r_tx_valid <= (w_state_nxt != IDLE);
      r_tx_data  <= frame_byte(w_frame_nxt, w_state_nxt);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dtree_result_tx.sv
`default_nettype none
// ============================================================================
// tb_dtree_result_tx : randomized self-checking bench for dtree_result_tx
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dtree_result_tx;

  localparam int FIFO_DEPTH = 8;
  localparam int DROP_WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  sample_strobe = 1'b0;
  logic                  in_valid = 1'b0;
  logic [1:0]            level = 2'd0;
  logic [1:0]            path = 2'd0;
  logic                  clear = 1'b0;
  logic                  tx_ready = 1'b0;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  overflow;
  logic [DROP_WIDTH-1:0] drop_count;

  int errors = 0;
  int checks = 0;
  int m_stamp = 0;
  int m_drops = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  dtree_result_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DROP_WIDTH (DROP_WIDTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_strobe (sample_strobe),
    .in_valid      (in_valid),
    .level         (level),
    .path          (path),
    .clear         (clear),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .overflow      (overflow),
    .drop_count    (drop_count)
  );

  // Collect every byte that actually transfers.
  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready) rx_q.push_back(tx_data);
  end

  function automatic void push_exp(input int stamp, input logic [1:0] lvl, input logic [1:0] pth);
    exp_q.push_back(8'(160 + 4 * int'(lvl) + int'(pth)));
    exp_q.push_back(8'(stamp / 256));
    exp_q.push_back(8'(stamp % 256));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle of input; acc says whether the model expects the result to be kept.
  task automatic drive(input bit iv, input bit st, input bit acc,
                       input logic [1:0] lvl, input logic [1:0] pth);
    in_valid      = iv;
    sample_strobe = st;
    level         = lvl;
    path          = pth;
    if (iv && acc) push_exp(m_stamp, lvl, pth);
    if (st) m_stamp = (m_stamp + 1) % 65536;
    step();
    in_valid      = 1'b0;
    sample_strobe = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    repeat (6) step();
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; sample_strobe = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_stamp = 0;
    m_drops = 0;
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++;
    if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++;
    if (drop_count !== '0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count); end
    step();
  endtask

  task automatic test_single();
    tx_ready = 1'b1;
    repeat (5) drive(1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 2'b01);
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_t1_idle: tx_valid=%b expected 0", tx_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[i])
        begin errors++; $display("FAIL single_byte%0d: valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, exp_q[i]); end
    end
    step();
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_after: tx_valid=%b expected 0", tx_valid); end
    step();
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok;
    tx_ready = 1'b1;
    drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    step();
    step();
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_q[1])
        begin errors++; $display("FAIL bp_hold%0d: valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, exp_q[1]); end
      step();
    end
    tx_ready = 1'b1;
    wait_bytes(exp_q.size(), 50, ok);
    checks++;
    if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_strobe_same_cycle();
    bit ok;
    tx_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    drive(1'b1, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    wait_bytes(exp_q.size(), 50, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size())
      begin errors++; $display("FAIL strobe_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL strobe_byte%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_overflow();
    bit ok;
    int occ;
    tx_ready = 1'b0;
    // First result parks in the frame register so the FIFO itself sees no pops.
    drive(1'b1, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    step();
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp_q[0])
      begin errors++; $display("FAIL ovf_blocker: valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, exp_q[0]); end
    step();
    occ = 0;
    for (int i = 0; i < 12; i++) begin
      bit acc;
      acc = (occ < FIFO_DEPTH);
      if (acc) occ++; else m_drops++;
      drive(1'b1, 1'($urandom_range(0, 1)), acc, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++;
    if (int'(drop_count) != m_drops) begin errors++; $display("FAIL ovf_drops: got %0d expected %0d", drop_count, m_drops); end
    // Clear and a drop together: the drop wins.
    clear = 1'b1;
    m_drops = 1;
    drive(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    clear = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1 || int'(drop_count) != m_drops)
      begin errors++; $display("FAIL clear_vs_drop: overflow=%b drops=%0d expected overflow=1 drops=%0d", overflow, drop_count, m_drops); end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== exp_q[0])
      begin errors++; $display("FAIL ovf_stall_hold: valid=%b data=%h expected valid=1 data=%h", tx_valid, tx_data, exp_q[0]); end
    step();
    tx_ready = 1'b1;
    step();
    step();
    // This cycle pops the full FIFO; the new result must still be dropped.
    m_drops++;
    drive(1'b1, 1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    @(negedge clk);
    checks++;
    if (int'(drop_count) != m_drops) begin errors++; $display("FAIL pop_full_drop: got %0d expected %0d", drop_count, m_drops); end
    wait_bytes(exp_q.size(), 200, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size())
      begin errors++; $display("FAIL ovf_frames: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    m_drops = 0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || drop_count !== '0)
      begin errors++; $display("FAIL clear_zero: overflow=%b drops=%0d expected 0 0", overflow, drop_count); end
    step();
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    for (int r = 0; r < 4; r++) begin
      int pushes;
      logic p_v, p_r;
      logic [7:0] p_d;
      pushes = 0;
      p_v = 1'b0; p_r = 1'b1; p_d = 8'h00;
      for (int c = 0; c < 40; c++) begin
        bit iv;
        tx_ready = ($urandom_range(0, 9) < 6);
        @(negedge clk);
        if (p_v && !p_r) begin
          checks++;
          if (tx_valid !== 1'b1 || tx_data !== p_d)
            begin errors++; $display("FAIL rnd_stable r%0d c%0d: valid=%b data=%h expected valid=1 data=%h", r, c, tx_valid, tx_data, p_d); end
        end
        p_v = tx_valid; p_r = tx_ready; p_d = tx_data;
        iv = (pushes < FIFO_DEPTH) && ($urandom_range(0, 2) == 0);
        if (iv) pushes++;
        drive(iv, 1'($urandom_range(0, 1)), iv, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end
      tx_ready = 1'b1;
      wait_bytes(exp_q.size(), 200, ok);
      checks++;
      if (!ok || rx_q.size() != exp_q.size())
        begin errors++; $display("FAIL rnd_count r%0d: got %0d bytes expected %0d", r, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        logic [7:0] got;
        got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
        checks++;
        if (got !== exp_q[i]) begin errors++; $display("FAIL rnd_byte r%0d i%0d: got %h expected %h", r, i, got, exp_q[i]); end
      end
      checks++;
      if (int'(drop_count) != m_drops) begin errors++; $display("FAIL rnd_drops r%0d: got %0d expected %0d", r, drop_count, m_drops); end
      exp_q.delete();
      rx_q.delete();
    end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    tx_ready = 1'b1;
    repeat (3) drive(1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    reset = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_async: tx_valid=%b expected 0", tx_valid); end
    repeat (3) step();
    reset = 1'b1;
    m_stamp = 0;
    m_drops = 0;
    exp_q.delete();
    rx_q.delete();
    repeat (6) step();
    checks++;
    if (rx_q.size() != 0) begin errors++; $display("FAIL rst_no_bytes: got %0d bytes expected 0", rx_q.size()); end
    drive(1'b1, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    wait_bytes(exp_q.size(), 50, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size())
      begin errors++; $display("FAIL rst_next_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL rst_next_byte%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    exp_q.delete();
    rx_q.delete();
  endtask

  task automatic test_stamp_wrap();
    bit ok;
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 65537; i++) drive(1'b0, 1'b1, 1'b0, 2'd0, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    wait_bytes(exp_q.size(), 50, ok);
    checks++;
    if (!ok || rx_q.size() != exp_q.size())
      begin errors++; $display("FAIL wrap_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL wrap_byte%0d: got %h expected %h", i, got, exp_q[i]); end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_strobe_same_cycle();
    test_overflow();
    test_random();
    test_reset_midframe();
    test_stamp_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
